// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter sharing one memory_controller port.
// Each winning request is registered and run to completion from those registered values.
module mem_bus_arbiter #(
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [15:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_ack,
   output logic [31:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [15:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_ack,
   output logic [31:0] b_rdata,
   output logic [15:0] mem_address,
   output logic [31:0] mem_data_out,
   output logic        mem_we,
   input  logic [31:0] mem_data_in,
   output logic        busy,
   output logic        grant
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic            grant_q, grant_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   a_rdata_q, a_rdata_d;
   logic [DW-1:0]   b_rdata_q, b_rdata_d;
   logic [AW-1:0]   mem_address_q, mem_address_d;
   logic [DW-1:0]   mem_data_out_q, mem_data_out_d;
   logic            mem_we_q, mem_we_d;
   logic            a_ack_q, a_ack_d;
   logic            b_ack_q, b_ack_d;
   logic            busy_q, busy_d;
   logic            pick_b;
   logic            capture;

   // Next-state, transaction capture and registered-output targets
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      pick_b    = 1'b0;
      capture   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (a_req || b_req) begin
               // On a tie the master that did not own the last transaction wins
               pick_b  = (a_req && b_req) ? ~grant_q : b_req;
               grant_d = pick_b;
               we_d    = pick_b ? b_we    : a_we;
               addr_d  = pick_b ? b_addr  : a_addr;
               wdata_d = pick_b ? b_wdata : a_wdata;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (we_q) begin
               state_d = S_DONE;
            end else if (READ_LATENCY == 0) begin
               capture = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d   = CW'(READ_LATENCY);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == CW'(1)) begin
               capture = 1'b1;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (capture) begin
         if (grant_q) b_rdata_d = mem_data_in;
         else         a_rdata_d = mem_data_in;
      end

      mem_we_d       = (state_d == S_ACCESS) && we_d;
      mem_address_d  = ((state_d == S_ACCESS) || (state_d == S_WAIT)) ? addr_d : '0;
      mem_data_out_d = (state_d == S_ACCESS) ? wdata_d : mem_data_out_q;
      a_ack_d        = (state_d == S_DONE) && !grant_d;
      b_ack_d        = (state_d == S_DONE) && grant_d;
      busy_d         = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         grant_q        <= 1'b1;
         we_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         cnt_q          <= '0;
         a_rdata_q      <= '0;
         b_rdata_q      <= '0;
         mem_address_q  <= '0;
         mem_data_out_q <= '0;
         mem_we_q       <= 1'b0;
         a_ack_q        <= 1'b0;
         b_ack_q        <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         we_q           <= we_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         cnt_q          <= cnt_d;
         a_rdata_q      <= a_rdata_d;
         b_rdata_q      <= b_rdata_d;
         mem_address_q  <= mem_address_d;
         mem_data_out_q <= mem_data_out_d;
         mem_we_q       <= mem_we_d;
         a_ack_q        <= a_ack_d;
         b_ack_q        <= b_ack_d;
         busy_q         <= busy_d;
      end
   end

   assign a_ack        = a_ack_q;
   assign b_ack        = b_ack_q;
   assign a_rdata      = a_rdata_q;
   assign b_rdata      = b_rdata_q;
   assign mem_address  = mem_address_q;
   assign mem_data_out = mem_data_out_q;
   assign mem_we       = mem_we_q;
   assign busy         = busy_q;
   assign grant        = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one READ_LATENCY=1 instance and one READ_LATENCY=0 instance.
module tb_mem_bus_arbiter;

   logic        clock;
   logic        reset;
   logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
   logic [15:0] a_addr, b_addr, mem_address;
   logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_data_out, mem_data_in;
   logic        mem_we, busy, grant;

   logic        z_reset;
   logic        z_a_req, z_a_we, z_a_ack, z_b_req, z_b_we, z_b_ack;
   logic [15:0] z_a_addr, z_b_addr, z_mem_address;
   logic [31:0] z_a_wdata, z_b_wdata, z_a_rdata, z_b_rdata, z_mem_data_out, z_mem_data_in;
   logic        z_mem_we, z_busy, z_grant;

   int n_chk;
   int n_fail;
   logic [31:0] exp_a, exp_b;
   logic        owner;

   function automatic logic [31:0] mem_model(input logic [15:0] addr);
      if (addr == 16'h0010)      return 32'h1234_5678;
      else if (addr == 16'hFFFF) return 32'hA5A5_A5A5;
      else                       return {16'hC0DE, addr};
   endfunction

   assign mem_data_in   = mem_model(mem_address);
   assign z_mem_data_in = mem_model(z_mem_address);

   mem_bus_arbiter #(.READ_LATENCY(1)) dut (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_we(mem_we),
      .mem_data_in(mem_data_in), .busy(busy), .grant(grant)
   );

   mem_bus_arbiter #(.READ_LATENCY(0)) dut_z (
      .clock(clock), .reset(z_reset),
      .a_req(z_a_req), .a_we(z_a_we), .a_addr(z_a_addr), .a_wdata(z_a_wdata),
      .a_ack(z_a_ack), .a_rdata(z_a_rdata),
      .b_req(z_b_req), .b_we(z_b_we), .b_addr(z_b_addr), .b_wdata(z_b_wdata),
      .b_ack(z_b_ack), .b_rdata(z_b_rdata),
      .mem_address(z_mem_address), .mem_data_out(z_mem_data_out), .mem_we(z_mem_we),
      .mem_data_in(z_mem_data_in), .busy(z_busy), .grant(z_grant)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset = 1'b1; a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      z_reset = 1'b1; z_a_req = 0; z_a_we = 0; z_a_addr = '0; z_a_wdata = '0;
      z_b_req = 0; z_b_we = 0; z_b_addr = '0; z_b_wdata = '0;
      tick(); tick();

      // Reset values
      chk("rst_a_ack", a_ack, 0);          chk("rst_b_ack", b_ack, 0);
      chk("rst_mem_we", mem_we, 0);        chk("rst_mem_addr", mem_address, 0);
      chk("rst_mem_dout", mem_data_out, 0);
      chk("rst_a_rdata", a_rdata, 0);      chk("rst_b_rdata", b_rdata, 0);
      chk("rst_busy", busy, 0);            chk("rst_grant", grant, 1);
      reset = 1'b0;

      // A write 0x0010 <= 0xDEADBEEF
      a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 32'hDEAD_BEEF;
      tick();
      chk("wr_access_we", mem_we, 1);      chk("wr_access_addr", mem_address, 32'h0010);
      chk("wr_access_dout", mem_data_out, 32'hDEAD_BEEF);
      chk("wr_access_grant", grant, 0);    chk("wr_access_busy", busy, 1);
      chk("wr_access_ack", a_ack, 0);
      tick();
      chk("wr_done_we", mem_we, 0);        chk("wr_done_a_ack", a_ack, 1);
      chk("wr_done_b_ack", b_ack, 0);      chk("wr_done_addr", mem_address, 0);
      chk("wr_a_rdata", a_rdata, 0);
      a_req = 0;
      tick();
      chk("wr_idle_ack", a_ack, 0);        chk("wr_idle_busy", busy, 0);

      // A read 0x0010, latency 1
      a_req = 1; a_we = 0; a_addr = 16'h0010;
      tick();
      chk("rd_access_we", mem_we, 0);      chk("rd_access_addr", mem_address, 32'h0010);
      chk("rd_access_ack", a_ack, 0);
      tick();
      chk("rd_wait_addr", mem_address, 32'h0010);
      chk("rd_wait_ack", a_ack, 0);        chk("rd_wait_busy", busy, 1);
      tick();
      chk("rd_done_a_ack", a_ack, 1);      chk("rd_done_b_ack", b_ack, 0);
      chk("rd_a_rdata", a_rdata, 32'h1234_5678);
      chk("rd_b_rdata", b_rdata, 0);
      a_req = 0;
      tick();
      chk("rd_idle_ack", a_ack, 0);        chk("rd_idle_busy", busy, 0);

      // Reset, then both masters read continuously for six transactions
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rr_rst_grant", grant, 1);       chk("rr_rst_a_rdata", a_rdata, 0);
      a_req = 1; a_we = 0; a_addr = 16'h0100;
      b_req = 1; b_we = 0; b_addr = 16'h0200;
      exp_a = 0; exp_b = 0;
      for (int t = 0; t < 6; t++) begin
         owner = (t % 2 == 1);
         tick();
         chk("rr_grant", grant, owner);    chk("rr_busy_access", busy, 1);
         chk("rr_mem_we", mem_we, 0);
         chk("rr_addr", mem_address, owner ? b_addr : a_addr);
         tick();
         chk("rr_wait_a_ack", a_ack, 0);   chk("rr_wait_b_ack", b_ack, 0);
         chk("rr_wait_we", mem_we, 0);
         tick();
         if (owner) exp_b = mem_model(b_addr);
         else       exp_a = mem_model(a_addr);
         chk("rr_done_a_ack", a_ack, !owner);
         chk("rr_done_b_ack", b_ack, owner);
         chk("rr_a_rdata", a_rdata, exp_a);
         chk("rr_b_rdata", b_rdata, exp_b);
         if (owner) begin
            if (t == 5) b_req = 0;
            else        b_addr = b_addr + 16'd1;
         end else begin
            if (t == 4) a_req = 0;
            else        a_addr = a_addr + 16'd1;
         end
         tick();
         chk("rr_idle_busy", busy, 0);
         chk("rr_idle_a_ack", a_ack, 0);   chk("rr_idle_b_ack", b_ack, 0);
      end
      tick();
      chk("rr_end_busy", busy, 0);

      // Reset during WAIT of a B read aborts it
      b_req = 1; b_we = 0; b_addr = 16'h0040;
      tick();
      chk("ab_grant", grant, 1);           chk("ab_busy", busy, 1);
      tick();
      chk("ab_wait_addr", mem_address, 32'h0040);
      reset = 1'b1;
      tick();
      chk("ab_busy_rst", busy, 0);         chk("ab_b_ack", b_ack, 0);
      chk("ab_b_rdata", b_rdata, 0);       chk("ab_grant_rst", grant, 1);
      chk("ab_addr_rst", mem_address, 0);
      reset = 1'b0; b_req = 0;
      tick();
      chk("ab_b_ack_after", b_ack, 0);     chk("ab_busy_after", busy, 0);

      // Zero-latency instance: B reads 0xFFFF
      z_reset = 1'b0;
      z_b_req = 1; z_b_we = 0; z_b_addr = 16'hFFFF;
      tick();
      chk("z_access_addr", z_mem_address, 32'hFFFF);
      chk("z_access_grant", z_grant, 1);   chk("z_access_we", z_mem_we, 0);
      tick();
      chk("z_done_b_ack", z_b_ack, 1);     chk("z_done_a_ack", z_a_ack, 0);
      chk("z_b_rdata", z_b_rdata, 32'hA5A5_A5A5);
      chk("z_a_rdata", z_a_rdata, 0);
      z_b_req = 0;
      tick();
      chk("z_idle_b_ack", z_b_ack, 0);     chk("z_idle_busy", z_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
